// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner issuing word fetches and buffering instructions for decode
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      instr_op,
    output logic [XLEN-1:0] instr_pc
);

    localparam int              PW    = $clog2(BUF_DEPTH);
    localparam int              CW    = PW + 1;
    localparam logic [CW-1:0]   DEPTH = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] target_aligned;
    logic [XLEN-1:0] buf_data [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc   [BUF_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            req_fire;
    logic            push;
    logic            pop;

    assign target_aligned = pc_target & ~XLEN'(3);
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = fetch_pc;
    assign instr_valid    = (count != '0);
    assign pop            = instr_valid && instr_ready;
    assign instr          = buf_data[rd_ptr];
    assign instr_pc       = buf_pc[rd_ptr];
    assign instr_op       = instr[6:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // A response always closes the outstanding request, even when a redirect coincides.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (req_fire) state_nxt = WAIT;
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = FETCH;
                end else if (pc_src) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   if (imem_rsp_valid) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Gating with rst keeps the request low while reset is held.
    always_comb begin
        imem_req_valid = 1'b0;
        push           = 1'b0;
        if (state == FETCH) begin
            imem_req_valid = rst && (count < DEPTH) && !pc_src;
        end
        if (state == WAIT) begin
            push = imem_rsp_valid && !pc_src;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
        end else if (pc_src) begin
            fetch_pc <= target_aligned;
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    // In WAIT fetch_pc has already stepped past the outstanding request, so its PC is fetch_pc - 4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (pc_src) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= imem_rsp_data;
                buf_pc[wr_ptr]   <= fetch_pc - XLEN'(4);
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, rsp_valid, pc_src, instr_valid, instr_ready;
    logic [31:0] req_addr, rsp_data, pc_target, instr, instr_pc;
    logic [6:0]  instr_op;

    logic        rst2 = 1'b0;
    logic        req_valid2, req_ready2, rsp2_valid, pc_src2, instr_valid2, instr_ready2;
    logic [31:0] req_addr2, rsp2_data, pc_target2, instr2, instr_pc2;
    logic [6:0]  instr_op2;

    int checks = 0;
    int errors = 0;

    logic        drv_req_ready = 1'b0;
    logic        drv_instr_ready = 1'b0;
    logic        drv_pc_src = 1'b0;
    logic [31:0] drv_target = 32'h0;
    int          lat_fix = 0;

    logic [63:0] exp_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] model_pc;
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_lat;
    logic [31:0] rsp_addr_last;
    logic        prev_stall;
    logic [31:0] prev_addr;
    int          cyc, first_acc, first_valid;
    logic [31:0] first_pc;
    logic [6:0]  first_op;
    logic [63:0] mon_e;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .pc_src(pc_src), .pc_target(pc_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_op(instr_op), .instr_pc(instr_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst2),
        .imem_req_valid(req_valid2), .imem_req_ready(req_ready2), .imem_req_addr(req_addr2),
        .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
        .pc_src(pc_src2), .pc_target(pc_target2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready2),
        .instr(instr2), .instr_op(instr_op2), .instr_pc(instr_pc2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0033;
        if (a == 32'h4) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic apply();
        req_ready   = drv_req_ready;
        instr_ready = drv_instr_ready;
        pc_src      = drv_pc_src;
        pc_target   = drv_target;
    endtask

    // Program-order model: accepted fetches must follow RESET_PC or the last redirect target in +4 steps.
    task automatic step();
        logic hs;
        apply();
        @(negedge clk);
        #1;
        hs = req_valid && req_ready;
        if (prev_stall && !pc_src) begin
            chk("req_hold", {req_valid, req_addr}, {1'b1, prev_addr});
        end
        if (pc_src) begin
            chk("no_req_on_redirect", req_valid, 1'b0);
            exp_q.delete();
            model_pc = {pc_target[31:2], 2'b00};
        end else if (hs) begin
            chk("req_addr", req_addr, model_pc);
            chk("one_outstanding", mem_pend, 1'b0);
            exp_q.push_back({model_pc, mem_fn(model_pc)});
            model_pc = model_pc + 32'd4;
            mem_pend = 1'b1;
            mem_addr = req_addr;
            mem_lat  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
            acc_log.push_back(req_addr);
            if (first_acc < 0) first_acc = cyc;
        end
        if (instr_valid && first_valid < 0) begin
            first_valid = cyc;
            first_pc    = instr_pc;
            first_op    = instr_op;
        end
        prev_stall = req_valid && !req_ready;
        prev_addr  = req_addr;
        cyc++;
        @(posedge clk);
        #1;
        if (mem_pend && mem_lat == 0) begin
            rsp_valid     = 1'b1;
            rsp_data      = mem_fn(mem_addr);
            rsp_addr_last = mem_addr;
            mem_pend      = 1'b0;
        end else begin
            rsp_valid = 1'b0;
            if (mem_pend) mem_lat--;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        drv_pc_src = 1'b0;
        apply();
        rsp_valid     = 1'b0;
        rsp_data      = 32'h0;
        exp_q.delete();
        acc_log.delete();
        pop_log.delete();
        model_pc      = 32'h0;
        mem_pend      = 1'b0;
        rsp_addr_last = 32'hFFFF_FFFF;
        prev_stall    = 1'b0;
        cyc           = 0;
        first_acc     = -1;
        first_valid   = -1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst && instr_valid && instr_ready) begin
            chk("pop_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("instr_pc", instr_pc, mon_e[63:32]);
                chk("instr", instr, mon_e[31:0]);
                chk("instr_op", instr_op, mon_e[6:0]);
            end
            pop_log.push_back(instr_pc);
        end
    end

    task automatic dut2_test();
        logic [31:0] log2[$];
        logic        acc;
        int          c;
        req_ready2 = 1'b1; instr_ready2 = 1'b1; rsp2_valid = 1'b0; rsp2_data = 32'h0;
        pc_src2 = 1'b0; pc_target2 = 32'h0;
        rst2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst2 = 1'b1;
        c = 0;
        while (log2.size() < 4 && c < 40) begin
            @(negedge clk);
            #1;
            acc = req_valid2 && req_ready2;
            if (acc) log2.push_back(req_addr2);
            @(posedge clk);
            #1;
            rsp2_valid = acc;
            rsp2_data  = 32'h0000_0013;
            if (log2.size() >= 3) instr_ready2 = 1'b0;
            c++;
        end
        chk("wrap_req_count", 64'(log2.size()), 64'd4);
        chk("wrap_addr0", qget(log2, 0), 32'hFFFF_FFF8);
        chk("wrap_addr1", qget(log2, 1), 32'hFFFF_FFFC);
        chk("wrap_addr2", qget(log2, 2), 32'h0000_0000);
        chk("pre_reset_valid", instr_valid2, 1'b1);
        #1 rst2 = 1'b0;
        #1;
        chk("async_rst_instr_valid", instr_valid2, 1'b0);
        chk("async_rst_req_valid", req_valid2, 1'b0);
        chk("async_rst_instr", {instr2, instr_op2}, 39'h0);
        chk("async_rst_instr_pc", instr_pc2, 32'h0);
        rsp2_valid = 1'b0;
    endtask

    initial begin
        int np;
        apply();
        rsp_valid = 1'b0; rsp_data = 32'h0;
        req_ready2 = 1'b0; instr_ready2 = 1'b0; rsp2_valid = 1'b0; rsp2_data = 32'h0;
        pc_src2 = 1'b0; pc_target2 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_valid", req_valid, 1'b0);
        chk("reset_instr_valid", instr_valid, 1'b0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_instr_pc", instr_pc, 32'h0);

        // Streaming with a 1-cycle memory.
        drv_req_ready = 1'b1; drv_instr_ready = 1'b1; lat_fix = 0;
        do_reset();
        repeat (10) step();
        chk("seq_addr0", qget(acc_log, 0), 32'h0);
        chk("seq_addr1", qget(acc_log, 1), 32'h4);
        chk("seq_addr2", qget(acc_log, 2), 32'h8);
        chk("first_valid_latency", 64'(first_valid - first_acc), 64'd2);
        chk("first_pc", first_pc, 32'h0);
        chk("first_op", first_op, 7'b0110011);

        // Decode stalled: buffer fills to depth and fetch stops.
        drv_instr_ready = 1'b0;
        do_reset();
        repeat (10) step();
        chk("fill_accepts", 64'(acc_log.size()), 64'd2);
        chk("fill_instr_valid", instr_valid, 1'b1);
        chk("fill_req_valid", req_valid, 1'b0);
        drv_instr_ready = 1'b1;
        for (int i = 0; i < 20 && acc_log.size() < 3; i++) step();
        chk("drain_pc0", qget(pop_log, 0), 32'h0);
        chk("drain_pc1", qget(pop_log, 1), 32'h4);
        chk("resume_addr", qget(acc_log, 2), 32'h8);

        // Redirect while the 0x8 request is outstanding.
        lat_fix = 2;
        do_reset();
        for (int i = 0; i < 40 && acc_log.size() < 3; i++) step();
        np = pop_log.size();
        drv_pc_src = 1'b1; drv_target = 32'h0000_0103;
        step();
        drv_pc_src = 1'b0;
        apply();
        #1;
        chk("redirect_flush", instr_valid, 1'b0);
        for (int i = 0; i < 20 && acc_log.size() < 4; i++) step();
        chk("redirect_req_addr", qget(acc_log, 3), 32'h100);
        for (int i = 0; i < 20 && pop_log.size() <= np; i++) step();
        chk("redirect_instr_pc", qget(pop_log, np), 32'h100);

        // Redirect coinciding with a response and a pop.
        lat_fix = 0; drv_instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 20 && !(rsp_valid && rsp_addr_last == 32'h4); i++) step();
        np = pop_log.size();
        drv_instr_ready = 1'b1; drv_pc_src = 1'b1; drv_target = 32'h0000_0200;
        step();
        chk("branch_pop_count", 64'(pop_log.size()), 64'(np + 1));
        chk("branch_pop_pc", qget(pop_log, np), 32'h0);
        drv_pc_src = 1'b0;
        apply();
        #1;
        chk("coincide_empty", instr_valid, 1'b0);
        chk("coincide_req", {req_valid, req_addr}, {1'b1, 32'h200});
        repeat (4) step();

        // Memory not ready: the request holds steady.
        drv_req_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_req", {req_valid, req_addr}, {1'b1, 32'h0});
        end
        chk("stall_no_accept", 64'(acc_log.size()), 64'd0);
        drv_req_ready = 1'b1;
        repeat (4) step();
        chk("stall_acc0", qget(acc_log, 0), 32'h0);
        chk("stall_acc1", qget(acc_log, 1), 32'h4);

        // Randomized traffic.
        lat_fix = -1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drv_req_ready   = ($urandom_range(0, 3) != 0);
            drv_instr_ready = ($urandom_range(0, 2) != 0);
            drv_pc_src      = ($urandom_range(0, 15) == 0);
            drv_target      = $urandom;
            step();
        end
        drv_pc_src = 1'b0; drv_req_ready = 1'b0; drv_instr_ready = 1'b1;
        repeat (12) step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        dut2_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
